ks_sum_stage: RTL and testbench

KS_SUM_STAGE -- requirements
Module: ks_sum_stage

---
 rtl/ks_pkg.sv | 19 +
 rtl/ks_sum_core.sv | 39 +++
 rtl/ks_sum_stage.sv | 109 ++++++++++
 tb/tb_ks_sum_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared width, buffer state encoding and result record for the Kogge-Stone sum stage.
package ks_pkg;

    localparam int KS_W = 25;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } ks_state_t;

    typedef struct packed {
        logic [KS_W-1:0] sum;
        logic            cout;
        logic            zero;
        logic            sign;
    } ks_result_t;

endpackage

// File: rtl/ks_sum_core.sv
// Final Kogge-Stone level: finishes the partial carry spans and forms sum, carry out and zero flag.
module ks_sum_core
    import ks_pkg::*;
(
    input  logic [KS_W-1:0] i_G,
    input  logic [KS_W-1:0] i_P,
    input  logic [KS_W-1:0] i_P0,
    input  logic            i_sign,
    output ks_result_t      o_res
);

    logic [15:0]     w_cLow;
    logic [7:0]      w_cMid;
    logic            w_cTop;
    logic [KS_W-1:0] w_cf;
    logic [KS_W-1:0] w_carry;
    logic [KS_W-1:0] w_sum;
    logic            w_unusedP;

    // Bits 15:0 already span down to bit 0, so only the upper spans need one more merge.
    assign w_cLow = i_G[15:0];

    for (genvar j = 0; j < 8; j++) begin : g_mid
        assign w_cMid[j] = i_G[16+j] | (i_P[16+j] & w_cLow[8+j]);
    end

    assign w_cTop    = i_G[24] | (i_P[24] & w_cLow[8]);
    assign w_cf      = {w_cTop, w_cMid, w_cLow};
    assign w_unusedP = ^i_P[15:0];

    assign w_carry = {w_cf[KS_W-2:0], 1'b0};
    assign w_sum   = i_P0 ^ w_carry;

    assign o_res.sum  = w_sum;
    assign o_res.cout = w_cf[KS_W-1];
    assign o_res.zero = (w_sum == '0);
    assign o_res.sign = i_sign;

endmodule

// File: rtl/ks_sum_stage.sv
// Sum stage with a two-entry skid buffer; in_ready comes only from registered state.
module ks_sum_stage
    import ks_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [KS_W-1:0] in_G,
    input  logic [KS_W-1:0] in_P,
    input  logic [KS_W-1:0] in_P0,
    input  logic            in_sign,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [KS_W-1:0] out_sum,
    output logic            out_cout,
    output logic            out_zero,
    output logic            out_sign
);

    ks_state_t  r_state;
    ks_state_t  w_nextState;
    ks_result_t r_main;
    ks_result_t r_skid;
    ks_result_t w_core;
    logic       w_inFire;
    logic       w_outFire;
    logic       w_loadMainNew;
    logic       w_loadMainSkid;
    logic       w_loadSkid;

    ks_sum_core u_core (
        .i_G    (in_G),
        .i_P    (in_P),
        .i_P0   (in_P0),
        .i_sign (in_sign),
        .o_res  (w_core)
    );

    assign in_ready  = (r_state != TWO);
    assign out_valid = (r_state != EMPTY);
    assign w_inFire  = in_valid & in_ready;
    assign w_outFire = out_valid & out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Main always holds the oldest word; skid only fills when main is stalled.
    always_comb begin
        w_nextState    = r_state;
        w_loadMainNew  = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_inFire) begin
                    w_nextState   = ONE;
                    w_loadMainNew = 1'b1;
                end
            end
            ONE: begin
                if (w_inFire && w_outFire) begin
                    w_loadMainNew = 1'b1;
                end else if (w_inFire) begin
                    w_nextState = TWO;
                    w_loadSkid  = 1'b1;
                end else if (w_outFire) begin
                    w_nextState = EMPTY;
                end
            end
            TWO: begin
                if (w_outFire) begin
                    w_nextState    = ONE;
                    w_loadMainSkid = 1'b1;
                end
            end
            default: begin
                w_nextState = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_loadMainNew) begin
                r_main <= w_core;
            end else if (w_loadMainSkid) begin
                r_main <= r_skid;
            end
            if (w_loadSkid) begin
                r_skid <= w_core;
            end
        end
    end

    assign out_sum  = r_main.sum;
    assign out_cout = r_main.cout;
    assign out_zero = r_main.zero;
    assign out_sign = r_main.sign;

endmodule

// File: tb/tb_ks_sum_stage.sv
// Scoreboard bench for ks_sum_stage: driver pushes expected words, a negedge monitor pops and compares.
module tb_ks_sum_stage;
    import ks_pkg::*;

    logic            clock;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [KS_W-1:0] in_G;
    logic [KS_W-1:0] in_P;
    logic [KS_W-1:0] in_P0;
    logic            in_sign;
    logic            out_valid;
    logic            out_ready;
    logic [KS_W-1:0] out_sum;
    logic            out_cout;
    logic            out_zero;
    logic            out_sign;

    int         errors = 0;
    int         checks = 0;
    int         outCount = 0;
    int         cycleCount = 0;
    bit         randomReady = 0;
    ks_result_t sb[$];

    ks_sum_stage dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_G      (in_G),
        .in_P      (in_P),
        .in_P0     (in_P0),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_zero  (out_zero),
        .out_sign  (out_sign)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    always @(posedge clock) begin
        if (randomReady) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference prefix expansion: group generate/propagate over the span each bit position carries.
    function automatic void expandOperands(input logic [KS_W-1:0] a, input logic [KS_W-1:0] b,
                                           output logic [KS_W-1:0] g, output logic [KS_W-1:0] p);
        for (int i = 0; i < KS_W; i++) begin
            int   lo;
            logic gg;
            logic pp;
            lo = (i <= 15) ? 0 : ((i <= 23) ? i - 7 : 9);
            gg = 1'b0;
            pp = 1'b1;
            for (int k = lo; k <= i; k++) begin
                gg = (a[k] & b[k]) | ((a[k] ^ b[k]) & gg);
                pp = pp & (a[k] ^ b[k]);
            end
            g[i] = gg;
            p[i] = pp;
        end
    endfunction

    task automatic driveOperands(input logic [KS_W-1:0] a, input logic [KS_W-1:0] b, input logic s);
        logic [KS_W-1:0] g;
        logic [KS_W-1:0] p;
        expandOperands(a, b, g, p);
        in_G     = g;
        in_P     = p;
        in_P0    = a ^ b;
        in_sign  = s;
        in_valid = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic applyStimulus(input logic [KS_W-1:0] a, input logic [KS_W-1:0] b, input logic s,
                                 input logic [KS_W-1:0] expSum, input logic expCout);
        ks_result_t exp;
        bit         accepted;
        accepted = 0;
        driveOperands(a, b, s);
        exp.sum  = expSum;
        exp.cout = expCout;
        exp.zero = (expSum == '0);
        exp.sign = s;
        for (int t = 0; t < 200 && !accepted; t++) begin
            @(negedge clock);
            if (in_ready) begin
                sb.push_back(exp);
                accepted = 1;
            end
            @(posedge clock);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles expected acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic applyRandomWord();
        logic [KS_W-1:0] a;
        logic [KS_W-1:0] b;
        logic [KS_W:0]   full;
        a    = KS_W'($urandom);
        b    = KS_W'($urandom);
        full = {1'b0, a} + {1'b0, b};
        applyStimulus(a, b, 1'($urandom_range(0, 1)), full[KS_W-1:0], full[KS_W]);
    endtask

    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL spurious_output: got sum=%0h with empty scoreboard expected no output", out_sum);
            end else begin
                ks_result_t exp;
                exp = sb.pop_front();
                checkOutput("out_word", {4'd0, out_sum, out_cout, out_zero, out_sign}, {4'd0, exp});
            end
            outCount++;
        end
    end

    initial begin
        int startCycle;
        int startOut;
        bit done;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_G      = '0;
        in_P      = '0;
        in_P0     = '0;
        in_sign   = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_outputs", {4'd0, out_sum, out_cout, out_zero, out_sign}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Full-width carry ripple; visible right after the accepting edge.
        applyStimulus(25'h0FFFFFF, 25'h0000001, 1'b0, 25'h1000000, 1'b0);
        checkOutput("latency_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("latency_sum", {7'd0, out_sum}, 32'h1000000);

        applyStimulus(25'h1FFFFFF, 25'h0000001, 1'b1, 25'h0000000, 1'b1);
        applyStimulus(25'h0000005, 25'h0000003, 1'b0, 25'h0000008, 1'b0);
        applyStimulus(25'h1000000, 25'h1000000, 1'b1, 25'h0000000, 1'b1);
        applyStimulus(25'h00FF00F, 25'h0000FF1, 1'b0, 25'h0100000, 1'b0);
        repeat (3) @(posedge clock);
        #1;

        // Backpressure: two words fill the buffer, the third must wait.
        out_ready = 1'b0;
        applyStimulus(25'h0000001, 25'h0000002, 1'b0, 25'h0000003, 1'b0);
        applyStimulus(25'h0000100, 25'h00000FF, 1'b1, 25'h00001FF, 1'b0);
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        driveOperands(25'h0ABCDEF, 25'h0111111, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("stall_hold", {4'd0, out_sum, out_cout, out_zero, out_sign},
                        {4'd0, 25'h0000003, 1'b0, 1'b0, 1'b0});
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(25'h0ABCDEF, 25'h0111111, 1'b0, 25'h0BCDF00, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        checkOutput("backpressure_drained", sb.size(), 32'd0);

        // Reset while two words are held: both must vanish.
        out_ready = 1'b0;
        applyStimulus(25'h0000010, 25'h0000020, 1'b1, 25'h0000030, 1'b0);
        applyStimulus(25'h0000040, 25'h0000050, 1'b1, 25'h0000090, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midreset_outputs", {4'd0, out_sum, out_cout, out_zero, out_sign}, 32'd0);
        sb.delete();
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midreset_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        applyStimulus(25'h0000007, 25'h0000009, 1'b1, 25'h0000010, 1'b0);
        repeat (2) @(posedge clock);
        #1;

        // Full-rate stream: 50 words must leave within 51 cycles.
        startCycle = cycleCount;
        startOut   = outCount;
        for (int k = 0; k < 50; k++) begin
            applyStimulus(25'(k * 3), 25'(k * 1000), k[0], 25'(k * 1003), 1'b0);
        end
        checkOutput("stream_accept_cycles", cycleCount - startCycle, 32'd50);
        done = 0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clock);
            #1;
            if (outCount - startOut >= 50) done = 1;
        end
        checkOutput("stream_outputs", outCount - startOut, 32'd50);
        checkOutput("stream_cycles_ok", {31'd0, (cycleCount - startCycle) <= 51}, 32'd1);
        @(posedge clock);
        #1;

        // Random handshake streaming against (a+b) mod 2^25.
        randomReady = 1;
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
            applyRandomWord();
        end
        randomReady = 0;
        @(posedge clock);
        #2;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && sb.size() != 0; t++) begin
            @(posedge clock);
            #1;
        end
        checkOutput("final_drain", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
